// File: rtl/tick_burst_gen_pkg.sv
// Shared definitions for tick_burst_gen.
// Holds the FSM state encoding used by the burst generator.
package tick_burst_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/tick_burst_gen.sv
// tick_burst_gen: emits a burst of `count` rectangular pulses on `out`, timed
// by an upstream single-cycle tick strobe. Each pulse is high for high_ticks
// ticks and low for low_ticks ticks between pulses. The last pulse has no
// trailing low phase. Completion is flagged by a one-cycle `done`.
//
// Ports:
//   clk        rising-edge system clock
//   reset      synchronous, active-high reset
//   tick       one-cycle time-base strobe
//   start      one-cycle burst request (accepted only in IDLE)
//   abort      cancel a burst in progress (wins over start/tick)
//   count      pulses per burst, latched at acceptance
//   high_ticks ticks per high phase, latched at acceptance (0 -> 1)
//   low_ticks  ticks per low phase, latched at acceptance (0 -> 1)
//   out        registered burst waveform
//   busy       registered, high from the cycle after acceptance through DONE
//   done       registered one-cycle completion strobe
//   remaining  registered count of pulses not yet started, incl. current high
module tick_burst_gen
  import tick_burst_gen_pkg::*;
#(
  parameter int CNT_W  = 4,
  parameter int TICK_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  count,
  input  logic [TICK_W-1:0] high_ticks,
  input  logic [TICK_W-1:0] low_ticks,
  output logic              out,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  remaining
);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  rem_reg, rem_next;
  logic [TICK_W-1:0] phase_reg, phase_next;
  logic [TICK_W-1:0] hi_len_reg, hi_len_next;
  logic [TICK_W-1:0] lo_len_reg, lo_len_next;
  logic              out_reg, busy_reg, done_reg;

  // A zero phase length would never terminate, so it is treated as one tick.
  logic [TICK_W-1:0] hi_eff, lo_eff;
  assign hi_eff = (high_ticks == '0) ? TICK_W'(1) : high_ticks;
  assign lo_eff = (low_ticks  == '0) ? TICK_W'(1) : low_ticks;

  always_comb begin
    state_next  = state_reg;
    rem_next    = rem_reg;
    phase_next  = phase_reg;
    hi_len_next = hi_len_reg;
    lo_len_next = lo_len_reg;

    if (abort && state_reg != ST_IDLE) begin
      // Abort outranks tick and start; leaves without a done strobe.
      state_next = ST_IDLE;
      rem_next   = '0;
      phase_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // A tick coinciding with acceptance is deliberately not counted.
          if (start && !abort) begin
            hi_len_next = hi_eff;
            lo_len_next = lo_eff;
            if (count != '0) begin
              state_next = ST_HIGH;
              rem_next   = count;
              phase_next = hi_eff;
            end else begin
              state_next = ST_DONE;
              rem_next   = '0;
            end
          end
        end
        ST_HIGH: begin
          if (tick) begin
            if (phase_reg == TICK_W'(1)) begin
              if (rem_reg > CNT_W'(1)) begin
                state_next = ST_LOW;
                rem_next   = rem_reg - CNT_W'(1);
                phase_next = lo_len_reg;
              end else begin
                state_next = ST_DONE;
                rem_next   = '0;
                phase_next = '0;
              end
            end else begin
              phase_next = phase_reg - TICK_W'(1);
            end
          end
        end
        ST_LOW: begin
          if (tick) begin
            if (phase_reg == TICK_W'(1)) begin
              state_next = ST_HIGH;
              phase_next = hi_len_reg;
            end else begin
              phase_next = phase_reg - TICK_W'(1);
            end
          end
        end
        ST_DONE: begin
          state_next = ST_IDLE;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      rem_reg    <= '0;
      phase_reg  <= '0;
      hi_len_reg <= '0;
      lo_len_reg <= '0;
      out_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rem_reg    <= rem_next;
      phase_reg  <= phase_next;
      hi_len_reg <= hi_len_next;
      lo_len_reg <= lo_len_next;
      // Outputs are registered copies of the next-state decode so they line
      // up exactly with the state they describe.
      out_reg    <= (state_next == ST_HIGH);
      busy_reg   <= (state_next != ST_IDLE);
      done_reg   <= (state_next == ST_DONE);
    end
  end

  assign out       = out_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign remaining = rem_reg;

endmodule

// File: tb/tb_tick_burst_gen.sv
// Self-checking bench for tick_burst_gen: table-driven burst sequences plus
// hand-written corner-case sequences. One line printed per transaction.
module tb_tick_burst_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick, start, abort;
  logic [3:0] count, high_ticks, low_ticks;
  logic       out, busy, done;
  logic [3:0] remaining;

  int errors = 0;
  int checks = 0;

  tick_burst_gen #(.CNT_W(4), .TICK_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .start      (start),
    .abort      (abort),
    .count      (count),
    .high_ticks (high_ticks),
    .low_ticks  (low_ticks),
    .out        (out),
    .busy       (busy),
    .done       (done),
    .remaining  (remaining)
  );

  always #5 clk = ~clk;

  // Inputs applied for one cycle, and the outputs expected right after
  // the following rising edge.
  typedef struct {
    logic       s, t, a;
    logic [3:0] cnt, hi, lo;
    logic       eo, eb, ed;
    logic [3:0] er;
  } vec_t;

  vec_t tab1[22];
  vec_t tab3[8];

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic run_vec(input string tag, input int idx, input vec_t v);
    start = v.s; tick = v.t; abort = v.a;
    count = v.cnt; high_ticks = v.hi; low_ticks = v.lo;
    @(posedge clk);
    #1;
    $display("%s[%0d] s=%0b t=%0b a=%0b -> out=%0b busy=%0b done=%0b rem=%0d",
             tag, idx, v.s, v.t, v.a, out, busy, done, remaining);
    chk({tag, ".out"},  int'(out),       int'(v.eo));
    chk({tag, ".busy"}, int'(busy),      int'(v.eb));
    chk({tag, ".done"}, int'(done),      int'(v.ed));
    chk({tag, ".rem"},  int'(remaining), int'(v.er));
  endtask

  task automatic cyc(input string tag, input logic s, t, a,
                     input logic [3:0] cnt, hi, lo,
                     input logic eo, eb, ed, input logic [3:0] er);
    vec_t v;
    v.s = s; v.t = t; v.a = a; v.cnt = cnt; v.hi = hi; v.lo = lo;
    v.eo = eo; v.eb = eb; v.ed = ed; v.er = er;
    run_vec(tag, 0, v);
  endtask

  initial begin
    reset = 1'b1; tick = 0; start = 0; abort = 0;
    count = 0; high_ticks = 0; low_ticks = 0;

    // Table 1: tick every 5 cycles (cycles 4, 9, 14, 19), start at cycle 0,
    // count=2 high=1 low=2. Row c drives cycle c; expectations are for c+1.
    for (int c = 0; c < 22; c++) begin
      int k;
      k = c + 1;
      tab1[c].s   = (c == 0);
      tab1[c].t   = (c % 5 == 4);
      tab1[c].a   = 1'b0;
      tab1[c].cnt = 4'd2;
      tab1[c].hi  = 4'd1;
      tab1[c].lo  = 4'd2;
      tab1[c].eo  = (k >= 1 && k <= 4) || (k >= 15 && k <= 19);
      tab1[c].eb  = (k >= 1 && k <= 20);
      tab1[c].ed  = (k == 20);
      tab1[c].er  = (k <= 4) ? 4'd2 : (k <= 19) ? 4'd1 : 4'd0;
    end

    // Table 3: count=3, zero phase lengths, tick every cycle.
    // Waveform 1,0,1,0,1 then DONE.
    tab3[0] = '{1'b1, 1'b1, 1'b0, 4'd3, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd3};
    tab3[1] = '{1'b0, 1'b1, 1'b0, 4'd3, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd2};
    tab3[2] = '{1'b0, 1'b1, 1'b0, 4'd3, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd2};
    tab3[3] = '{1'b0, 1'b1, 1'b0, 4'd3, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd1};
    tab3[4] = '{1'b0, 1'b1, 1'b0, 4'd3, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd1};
    tab3[5] = '{1'b0, 1'b1, 1'b0, 4'd3, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd0};
    tab3[6] = '{1'b0, 1'b1, 1'b0, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0};
    tab3[7] = '{1'b0, 1'b1, 1'b0, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0};

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    $display("reset: out=%0b busy=%0b done=%0b rem=%0d", out, busy, done, remaining);
    chk("reset.out",  int'(out),       0);
    chk("reset.busy", int'(busy),      0);
    chk("reset.done", int'(done),      0);
    chk("reset.rem",  int'(remaining), 0);
    reset = 1'b0;

    for (int i = 0; i < 22; i++) run_vec("slow", i, tab1[i]);
    for (int i = 0; i < 8; i++)  run_vec("fast", i, tab3[i]);

    // count=0: straight to DONE, out never rises, busy only in the DONE cycle.
    cyc("zero0", 1, 0, 0, 4'd0, 4'd1, 4'd1, 0, 1, 1, 4'd0);
    cyc("zero1", 0, 0, 0, 4'd0, 4'd1, 4'd1, 0, 0, 0, 4'd0);
    cyc("zero2", 0, 1, 0, 4'd0, 4'd1, 4'd1, 0, 0, 0, 4'd0);

    // start+abort together in IDLE: abort wins, start dropped.
    cyc("sa0", 1, 0, 1, 4'd2, 4'd1, 4'd1, 0, 0, 0, 4'd0);
    cyc("sa1", 0, 0, 0, 4'd2, 4'd1, 4'd1, 0, 0, 0, 4'd0);

    // Abort during the second low phase (count=4, high=1, low=2, tick each cycle).
    cyc("ab0", 1, 0, 0, 4'd4, 4'd1, 4'd2, 1, 1, 0, 4'd4);
    cyc("ab1", 0, 1, 0, 4'd4, 4'd1, 4'd2, 0, 1, 0, 4'd3);
    cyc("ab2", 0, 1, 0, 4'd4, 4'd1, 4'd2, 0, 1, 0, 4'd3);
    cyc("ab3", 0, 1, 0, 4'd4, 4'd1, 4'd2, 1, 1, 0, 4'd3);
    cyc("ab4", 0, 1, 0, 4'd4, 4'd1, 4'd2, 0, 1, 0, 4'd2);
    cyc("ab5", 0, 1, 1, 4'd4, 4'd1, 4'd2, 0, 0, 0, 4'd0);
    cyc("ab6", 1, 0, 0, 4'd1, 4'd1, 4'd1, 1, 1, 0, 4'd1);
    cyc("ab7", 0, 1, 0, 4'd1, 4'd1, 4'd1, 0, 1, 1, 4'd0);
    cyc("ab8", 0, 0, 0, 4'd1, 4'd1, 4'd1, 0, 0, 0, 4'd0);

    // Restart mid-burst with changed operands is ignored; start in DONE ignored.
    cyc("rs0", 1, 0, 0, 4'd2, 4'd2, 4'd1, 1, 1, 0, 4'd2);
    cyc("rs1", 1, 1, 0, 4'd7, 4'd5, 4'd5, 1, 1, 0, 4'd2);
    cyc("rs2", 0, 1, 0, 4'd7, 4'd5, 4'd5, 0, 1, 0, 4'd1);
    cyc("rs3", 0, 1, 0, 4'd7, 4'd5, 4'd5, 1, 1, 0, 4'd1);
    cyc("rs4", 0, 1, 0, 4'd7, 4'd5, 4'd5, 1, 1, 0, 4'd1);
    cyc("rs5", 0, 1, 0, 4'd7, 4'd5, 4'd5, 0, 1, 1, 4'd0);
    cyc("rs6", 1, 0, 0, 4'd7, 4'd5, 4'd5, 0, 0, 0, 4'd0);
    cyc("rs7", 0, 0, 0, 4'd7, 4'd5, 4'd5, 0, 0, 0, 4'd0);

    // Reset mid-HIGH clears everything on the next edge.
    cyc("rst0", 1, 0, 0, 4'd3, 4'd3, 4'd1, 1, 1, 0, 4'd3);
    reset = 1'b1;
    cyc("rst1", 0, 1, 0, 4'd3, 4'd3, 4'd1, 0, 0, 0, 4'd0);
    reset = 1'b0;
    cyc("rst2", 0, 1, 0, 4'd3, 4'd3, 4'd1, 0, 0, 0, 4'd0);

    // Tick in the acceptance cycle is not counted (high=1).
    cyc("ts0", 1, 1, 0, 4'd1, 4'd1, 4'd1, 1, 1, 0, 4'd1);
    cyc("ts1", 0, 0, 0, 4'd1, 4'd1, 4'd1, 1, 1, 0, 4'd1);
    cyc("ts2", 0, 0, 0, 4'd1, 4'd1, 4'd1, 1, 1, 0, 4'd1);
    cyc("ts3", 0, 1, 0, 4'd1, 4'd1, 4'd1, 0, 1, 1, 4'd0);
    cyc("ts4", 0, 0, 0, 4'd1, 4'd1, 4'd1, 0, 0, 0, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
